// File: rtl/key_draw_ctrl_if.sv
// rtl/key_draw_ctrl_if.sv - event, position-LUT and VGA plot signals of key_draw_ctrl
interface key_draw_ctrl_if;
  logic       ev_valid;
  logic [7:0] ev_key;
  logic       ev_down;
  logic       ev_ready;
  logic       ev_dropped;
  logic [7:0] lut_key;
  logic [7:0] lut_x;
  logic [6:0] lut_y;
  logic       lut_hit;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  modport master (
    output ev_valid, ev_key, ev_down, lut_x, lut_y, lut_hit,
    input  ev_ready, ev_dropped, lut_key, vga_x, vga_y, vga_colour, vga_plot, busy
  );

  modport slave (
    input  ev_valid, ev_key, ev_down, lut_x, lut_y, lut_hit,
    output ev_ready, ev_dropped, lut_key, vga_x, vga_y, vga_colour, vga_plot, busy
  );
endinterface

// File: rtl/key_draw_ctrl.sv
// rtl/key_draw_ctrl.sv - queues key events and plots a highlight box per key, one pixel per clock
module key_draw_ctrl #(
  parameter int unsigned BOX_W      = 4,
  parameter int unsigned BOX_H      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [2:0]  COL_ON     = 3'b111,
  parameter logic [2:0]  COL_OFF    = 3'b000
) (
  input  logic           clock,
  input  logic           resetn,
  key_draw_ctrl_if.slave bus
);
  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE  = (PW + 1)'(1);
  localparam logic [7:0]  CX_LAST  = 8'(BOX_W - 1);
  localparam logic [7:0]  CY_LAST  = 8'(BOX_H - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, DRAW} state_t;

  state_t      state_q, state_d;
  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  lut_key_q, lut_key_d;
  logic        dir_q, dir_d;
  logic [7:0]  ox_q, ox_d;
  logic [6:0]  oy_q, oy_d;
  logic [7:0]  cx_q, cx_d;
  logic [7:0]  cy_q, cy_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_col_q, vga_col_d;
  logic        vga_plot_q, vga_plot_d;

  logic        empty, full, push;
  logic [8:0]  head;
  logic        load_pix, in_range;
  logic [7:0]  pix_ox, pix_cx, pix_cy;
  logic [6:0]  pix_oy;
  logic [8:0]  px;
  logic [7:0]  py;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push  = bus.ev_valid && !full;
  assign head  = mem_q[rd_ptr_q[PW-1:0]];

  assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= {bus.ev_key, bus.ev_down};
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    lut_key_d  = lut_key_q;
    dir_d      = dir_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    vga_x_d    = vga_x_q;
    vga_y_d    = vga_y_q;
    vga_col_d  = vga_col_q;
    vga_plot_d = 1'b0;
    load_pix   = 1'b0;
    pix_ox     = ox_q;
    pix_oy     = oy_q;
    pix_cx     = cx_q;
    pix_cy     = cy_q;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          lut_key_d = head[8:1];
          dir_d     = head[0];
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.lut_hit) begin
          ox_d     = bus.lut_x;
          oy_d     = bus.lut_y;
          cx_d     = '0;
          cy_d     = '0;
          pix_ox   = bus.lut_x;
          pix_oy   = bus.lut_y;
          pix_cx   = '0;
          pix_cy   = '0;
          load_pix = 1'b1;
          state_d  = DRAW;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        if (cx_q == CX_LAST && cy_q == CY_LAST) begin
          state_d = IDLE;
        end else begin
          if (cx_q == CX_LAST) begin
            cx_d = '0;
            cy_d = cy_q + 8'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
          pix_cx   = cx_d;
          pix_cy   = cy_d;
          load_pix = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sums are one bit wider than the screen coordinates so off-screen pixels clip instead of wrapping.
    px       = {1'b0, pix_ox} + {1'b0, pix_cx};
    py       = {1'b0, pix_oy} + pix_cy;
    in_range = (px <= 9'd159) && (py <= 8'd119);

    if (load_pix && in_range) begin
      vga_plot_d = 1'b1;
      vga_x_d    = px[7:0];
      vga_y_d    = py[6:0];
      vga_col_d  = dir_q ? COL_ON : COL_OFF;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lut_key_q  <= '0;
      dir_q      <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      vga_col_q  <= '0;
      vga_plot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lut_key_q  <= lut_key_d;
      dir_q      <= dir_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      vga_col_q  <= vga_col_d;
      vga_plot_q <= vga_plot_d;
    end
  end

  assign bus.ev_ready   = !full;
  assign bus.ev_dropped = bus.ev_valid && full;
  assign bus.lut_key    = lut_key_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_col_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.busy       = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_key_draw_ctrl.sv
// tb/tb_key_draw_ctrl.sv - scoreboard bench for key_draw_ctrl with a box-drawing reference model
module tb_key_draw_ctrl;
  localparam int BW = 4;
  localparam int BH = 4;

  logic clock;
  logic resetn;
  key_draw_ctrl_if bus ();

  key_draw_ctrl #(
    .BOX_W(BW), .BOX_H(BH), .FIFO_DEPTH(4), .COL_ON(3'b111), .COL_OFF(3'b000)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int plot_count = 0;
  int last_plot_cyc = 0;
  int plot_cycs[$];
  logic [17:0] exp_q[$];

  logic [7:0] tab_x   [256];
  logic [6:0] tab_y   [256];
  logic       tab_hit [256];

  assign bus.lut_x   = tab_x[bus.lut_key];
  assign bus.lut_y   = tab_y[bus.lut_key];
  assign bus.lut_hit = tab_hit[bus.lut_key];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Expected pixels of a whole box, clipped to the 160x120 screen.
  task automatic model_push(input logic [7:0] k, input logic d);
    int x, y;
    if (!tab_hit[k]) return;
    for (int cy = 0; cy < BH; cy++) begin
      for (int cx = 0; cx < BW; cx++) begin
        x = int'(tab_x[k]) + cx;
        y = int'(tab_y[k]) + cy;
        if (x < 160 && y < 120) exp_q.push_back({x[7:0], y[6:0], d ? 3'b111 : 3'b000});
      end
    end
  endtask

  task automatic offer(input logic [7:0] k, input logic d, output logic acc);
    @(negedge clock);
    bus.ev_valid = 1'b1;
    bus.ev_key   = k;
    bus.ev_down  = d;
    #1;
    acc = bus.ev_ready;
    chk("ev_dropped_vs_ready", bus.ev_dropped, !acc);
    if (acc) model_push(k, d);
  endtask

  task automatic stop_ev();
    @(negedge clock);
    bus.ev_valid = 1'b0;
    #1;
  endtask

  task automatic wait_idle(output int c);
    int n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (bus.busy && n < 500);
    chk("idle_timeout", (n >= 500), 0);
    chk("scoreboard_leftover", exp_q.size(), 0);
    c = cyc;
  endtask

  task automatic wait_plots(input int target);
    int n = 0;
    while (plot_count < target && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("plot_wait_timeout", (plot_count >= target), 1);
  endtask

  logic [17:0] mon_got, mon_exp;
  initial begin
    forever begin
      @(negedge clock);
      if (resetn && bus.vga_plot) begin
        plot_count++;
        last_plot_cyc = cyc;
        plot_cycs.push_back(cyc);
        mon_got = {bus.vga_x, bus.vga_y, bus.vga_colour};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d want none",
                   bus.vga_x, bus.vga_y, bus.vga_colour);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                     mon_got[17:10], mon_got[9:3], mon_got[2:0],
                     mon_exp[17:10], mon_exp[9:3], mon_exp[2:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] klist [12];
  logic       acc;
  int         c_end, base, n;
  logic       exp_acc [5];

  initial begin
    for (int i = 0; i < 256; i++) begin
      tab_x[i] = '0; tab_y[i] = '0; tab_hit[i] = 1'b0;
    end
    tab_x[5]  = 8'd52;  tab_y[5]  = 7'd30;  tab_hit[5]  = 1'b1;
    tab_x[10] = 8'd52;  tab_y[10] = 7'd76;  tab_hit[10] = 1'b1;
    tab_x[7]  = 8'd158; tab_y[7]  = 7'd118; tab_hit[7]  = 1'b1;
    tab_x[6]  = 8'd200; tab_y[6]  = 7'd130; tab_hit[6]  = 1'b1;
    tab_x[0]  = 8'd10;  tab_y[0]  = 7'd10;  tab_hit[0]  = 1'b0;
    for (int i = 20; i < 28; i++) begin
      tab_x[i]   = 8'($urandom_range(0, 170));
      tab_y[i]   = 7'($urandom_range(0, 125));
      tab_hit[i] = 1'b1;
    end
    klist = '{8'd5, 8'd10, 8'd0, 8'd7, 8'd6, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd26, 8'd27};

    bus.ev_valid = 1'b0;
    bus.ev_key   = '0;
    bus.ev_down  = 1'b0;
    resetn       = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_ev_ready", bus.ev_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_plot", bus.vga_plot, 0);
    chk("rst_vga_x", bus.vga_x, 0);
    chk("rst_vga_y", bus.vga_y, 0);
    chk("rst_colour", bus.vga_colour, 0);
    chk("rst_lut_key", bus.lut_key, 0);
    chk("rst_dropped", bus.ev_dropped, 0);
    @(negedge clock);
    resetn = 1'b1;

    // 1: press key 5, latency and busy fall
    offer(8'd5, 1'b1, acc);
    chk("t1_accept", acc, 1);
    stop_ev();
    chk("t1_plot_e1", bus.vga_plot, 0);
    chk("t1_busy_e1", bus.busy, 1);
    @(negedge clock); #1;
    chk("t1_plot_e2", bus.vga_plot, 0);
    @(negedge clock); #1;
    chk("t1_plot_e3", bus.vga_plot, 1);
    wait_idle(c_end);
    chk("t1_busy_fall", c_end, last_plot_cyc + 1);
    chk("t1_plot_total", plot_count, 16);

    // 2: release key 10
    offer(8'd10, 1'b0, acc);
    chk("t2_accept", acc, 1);
    stop_ev();
    wait_idle(c_end);
    chk("t2_busy_fall", c_end, last_plot_cyc + 1);
    chk("t2_plot_total", plot_count, 32);

    // 3: unmapped key
    base = plot_count;
    offer(8'd0, 1'b1, acc);
    stop_ev();
    chk("t3_busy_e1", bus.busy, 1);
    @(negedge clock); #1;
    chk("t3_busy_e2", bus.busy, 1);
    @(negedge clock); #1;
    chk("t3_busy_e3", bus.busy, 0);
    repeat (3) @(negedge clock);
    chk("t3_no_plots", plot_count, base);

    // 4: overflow while drawing, order and gaps
    plot_cycs.delete();
    base = plot_count;
    offer(8'd5, 1'b1, acc);
    stop_ev();
    wait_plots(base + 1);
    exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      offer((i % 2 == 0) ? 8'd10 : 8'd5, (i % 2 == 0) ? 1'b0 : 1'b1, acc);
      chk($sformatf("t4_accept_%0d", i), acc, exp_acc[i]);
      if (i == 4) chk("t4_dropped", bus.ev_dropped, 1);
    end
    stop_ev();
    wait_idle(c_end);
    chk("t4_plot_cnt", plot_cycs.size(), 80);
    if (plot_cycs.size() == 80) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t4_box_len_%0d", i), plot_cycs[16*i+15] - plot_cycs[16*i], 15);
        if (i > 0) chk($sformatf("t4_gap_%0d", i), plot_cycs[16*i] - plot_cycs[16*i-1], 3);
      end
    end

    // 5: clipping at the screen corner and fully off-screen
    base = plot_count;
    offer(8'd7, 1'b1, acc);
    stop_ev();
    wait_idle(c_end);
    chk("t5_corner_plots", plot_count - base, 4);
    base = plot_count;
    offer(8'd6, 1'b1, acc);
    stop_ev();
    n = 1;
    while (bus.busy && n < 100) begin
      @(negedge clock); #1;
      if (bus.busy) n++;
    end
    chk("t5_offscreen_busy_cycles", n, 2 + BW * BH);
    chk("t5_offscreen_plots", plot_count - base, 0);

    // 6: reset on the 7th pixel with another event queued
    base = plot_count;
    offer(8'd5, 1'b1, acc);
    offer(8'd10, 1'b1, acc);
    stop_ev();
    wait_plots(base + 7);
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_plot", bus.vga_plot, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_ready", bus.ev_ready, 1);
    chk("t6_vga_x", bus.vga_x, 0);
    chk("t6_colour", bus.vga_colour, 0);
    chk("t6_lut_key", bus.lut_key, 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (25) @(negedge clock);
    #1;
    chk("t6_no_resume", plot_count, base + 7);
    chk("t6_busy_after", bus.busy, 0);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        offer(klist[$urandom_range(0, 11)], 1'($urandom_range(0, 1)), acc);
      end else begin
        stop_ev();
      end
    end
    stop_ev();
    wait_idle(c_end);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
